// File: rtl/vgachargen_pkg.sv
// Shared constants and types for the vgachargen character console front end:
// grid defaults, ASCII control codes, and FSM/cursor-operation enums.
package vgachargen_pkg;

  localparam int COLS_DEFAULT   = 80;
  localparam int ROWS_DEFAULT   = 30;
  localparam int CHAR_MAP_WORDS = COLS_DEFAULT * ROWS_DEFAULT / 4;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TILDE = 8'h7E;

  typedef enum logic {ST_IDLE, ST_CLEAR} console_state_t;

  typedef enum logic [2:0] {
    CUR_NONE,
    CUR_ADVANCE,
    CUR_NEWLINE,
    CUR_RETURN,
    CUR_BACK,
    CUR_HOME
  } cursor_op_t;

  // Byte lane of a linear character index within its 32-bit char_map word.
  function automatic logic [3:0] lane_enable(input logic [11:0] lin);
    return 4'b0001 << lin[1:0];
  endfunction

endpackage

// File: rtl/vgachargen_cursor.sv
// Text cursor for the console: row/column counters with advance, newline,
// carriage return, backspace and home; also exposes the linear cell index.
module vgachargen_cursor
  import vgachargen_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  cursor_op_t  op_i,
  output logic [6:0]  col_o,
  output logic [4:0]  row_o,
  output logic [11:0] lin_o
);

  logic [6:0] col_q, col_d;
  logic [4:0] row_q, row_d;
  logic [4:0] row_next;

  // No scrolling: the bottom row wraps to the top.
  assign row_next = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    case (op_i)
      CUR_ADVANCE: begin
        if (col_q == 7'(COLS - 1)) begin
          col_d = 7'd0;
          row_d = row_next;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      CUR_NEWLINE: begin
        col_d = 7'd0;
        row_d = row_next;
      end
      CUR_RETURN: col_d = 7'd0;
      CUR_BACK:   if (col_q != 7'd0) col_d = col_q - 7'd1;
      CUR_HOME: begin
        col_d = 7'd0;
        row_d = 5'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      col_q <= 7'd0;
      row_q <= 5'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;
  assign lin_o = {7'd0, row_q} * 12'(COLS) + {5'd0, col_q};

endmodule

// File: rtl/vgachargen_console.sv
// ASCII stream to char_map write port, with CR/LF/BS/FF handling.
// Optional VGACHARGEN_CONSOLE_COLOR_EN adds a parallel col_map write port.
//   state    | meaning
//   ST_IDLE  | accepting bytes, one per cycle
//   ST_CLEAR | sweeping spaces over every char_map word, input stalled
module vgachargen_console
  import vgachargen_pkg::*;
#(
  parameter int COLS   = COLS_DEFAULT,
  parameter int ROWS   = ROWS_DEFAULT,
  parameter int MAP_AW = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              char_valid_i,
  input  logic [7:0]        char_data_i,
  output logic              char_ready_o,
  output logic [MAP_AW-1:0] char_map_addr_o,
  output logic              char_map_we_o,
  output logic [3:0]        char_map_be_o,
  output logic [31:0]       char_map_wdata_o,
`ifdef VGACHARGEN_CONSOLE_COLOR_EN
  input  logic [7:0]        color_i,
  output logic [MAP_AW-1:0] col_map_addr_o,
  output logic              col_map_we_o,
  output logic [3:0]        col_map_be_o,
  output logic [31:0]       col_map_wdata_o,
`endif
  output logic [6:0]        cursor_col_o,
  output logic [4:0]        cursor_row_o,
  output logic              busy_o
);

  localparam int WORDS = COLS * ROWS / 4;
  localparam logic [MAP_AW-1:0] LAST_WORD = MAP_AW'(WORDS - 1);

  console_state_t    state_q, state_d;
  logic              we_q, we_d;
  logic [MAP_AW-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  cursor_op_t        op;
  logic [11:0]       lin, lin_bs;
  logic [6:0]        col;
  logic [4:0]        row;

  vgachargen_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .op_i  (op),
    .col_o (col),
    .row_o (row),
    .lin_o (lin)
  );

  assign lin_bs = lin - 12'd1;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    op      = CUR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (char_valid_i) begin
          if (char_data_i >= ASCII_SPACE && char_data_i <= ASCII_TILDE) begin
            we_d    = 1'b1;
            addr_d  = MAP_AW'(lin[11:2]);
            be_d    = lane_enable(lin);
            wdata_d = {4{char_data_i}};
            op      = CUR_ADVANCE;
          end else begin
            case (char_data_i)
              ASCII_LF: op = CUR_NEWLINE;
              ASCII_CR: op = CUR_RETURN;
              ASCII_BS: begin
                // Backspace at column 0 is a no-op; it never climbs rows.
                if (col != 7'd0) begin
                  we_d    = 1'b1;
                  addr_d  = MAP_AW'(lin_bs[11:2]);
                  be_d    = lane_enable(lin_bs);
                  wdata_d = {4{ASCII_SPACE}};
                  op      = CUR_BACK;
                end
              end
              ASCII_FF: begin
                state_d = ST_CLEAR;
                we_d    = 1'b1;
                addr_d  = '0;
                be_d    = 4'hF;
                wdata_d = {4{ASCII_SPACE}};
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        if (addr_q == LAST_WORD) begin
          state_d = ST_IDLE;
          op      = CUR_HOME;
        end else begin
          we_d   = 1'b1;
          addr_d = addr_q + MAP_AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef VGACHARGEN_CONSOLE_COLOR_EN
  logic [7:0]  color_q, color_d;
  logic [31:0] cwdata_q, cwdata_d;
  logic        accept;

  assign accept = char_valid_i && (state_q == ST_IDLE);

  // The accepting byte's own color is used for its write; the sweep reuses
  // the color captured with FF.
  always_comb begin
    color_d  = accept ? color_i : color_q;
    cwdata_d = cwdata_q;
    if (we_d) cwdata_d = {4{color_d}};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      color_q  <= 8'h0;
      cwdata_q <= 32'h0;
    end else begin
      color_q  <= color_d;
      cwdata_q <= cwdata_d;
    end
  end

  assign col_map_addr_o  = addr_q;
  assign col_map_we_o    = we_q;
  assign col_map_be_o    = be_q;
  assign col_map_wdata_o = cwdata_q;
`endif

  assign char_ready_o     = (state_q == ST_IDLE);
  assign busy_o           = (state_q == ST_CLEAR);
  assign char_map_addr_o  = addr_q;
  assign char_map_we_o    = we_q;
  assign char_map_be_o    = be_q;
  assign char_map_wdata_o = wdata_q;
  assign cursor_col_o     = col;
  assign cursor_row_o     = row;

endmodule

// File: tb/tb_vgachargen_console.sv
// Bench for vgachargen_console: a linear-index screen model checked every
// cycle, directed scenarios with literal expectations, and random streams.
module tb_vgachargen_console;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        char_valid_i;
  logic [7:0]  char_data_i;
  logic [7:0]  color_i;
  logic        char_ready_o;
  logic [9:0]  char_map_addr_o;
  logic        char_map_we_o;
  logic [3:0]  char_map_be_o;
  logic [31:0] char_map_wdata_o;
  logic [6:0]  cursor_col_o;
  logic [4:0]  cursor_row_o;
  logic        busy_o;
`ifdef VGACHARGEN_CONSOLE_COLOR_EN
  logic [9:0]  col_map_addr_o;
  logic        col_map_we_o;
  logic [3:0]  col_map_be_o;
  logic [31:0] col_map_wdata_o;
`endif

  always #5 clk = ~clk;

  vgachargen_console dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .char_valid_i     (char_valid_i),
    .char_data_i      (char_data_i),
    .char_ready_o     (char_ready_o),
    .char_map_addr_o  (char_map_addr_o),
    .char_map_we_o    (char_map_we_o),
    .char_map_be_o    (char_map_be_o),
    .char_map_wdata_o (char_map_wdata_o),
`ifdef VGACHARGEN_CONSOLE_COLOR_EN
    .color_i          (color_i),
    .col_map_addr_o   (col_map_addr_o),
    .col_map_we_o     (col_map_we_o),
    .col_map_be_o     (col_map_be_o),
    .col_map_wdata_o  (col_map_wdata_o),
`endif
    .cursor_col_o     (cursor_col_o),
    .cursor_row_o     (cursor_row_o),
    .busy_o           (busy_o)
  );

  int n_vec = 0;
  int n_mis = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Screen model: cursor as (col,row), clear sweep as "next word to write".
  int          m_col, m_row, m_sweep;
  bit          m_last_acc;
  logic [7:0]  m_color;
  bit          e_we;
  int          e_addr;
  logic [3:0]  e_be;
  logic [31:0] e_wd, e_cwd;

  task automatic put_cell(input int lin, input logic [7:0] b);
    e_we   = 1;
    e_addr = lin / 4;
    e_be   = 4'(1 << (lin % 4));
    e_wd   = {4{b}};
    e_cwd  = {4{m_color}};
  endtask

  always @(posedge clk) begin
    int lin;
    logic [7:0] b;
    if (rst_i) begin
      m_col = 0; m_row = 0; m_sweep = 0; m_last_acc = 0; m_color = 0;
      e_we = 0; e_addr = 0; e_be = 0; e_wd = 0; e_cwd = 0;
    end else begin
      e_we = 0;
      m_last_acc = 0;
      if (m_sweep == 600) begin
        m_sweep = 0; m_col = 0; m_row = 0;
      end else if (m_sweep > 0) begin
        e_we = 1; e_addr = m_sweep; e_be = 4'hF; e_wd = 32'h20202020;
        e_cwd = {4{m_color}};
        m_sweep++;
      end else if (char_valid_i) begin
        m_last_acc = 1;
        m_color = color_i;
        b = char_data_i;
        lin = m_row * 80 + m_col;
        if (b >= 8'h20 && b <= 8'h7E) begin
          put_cell(lin, b);
          lin = (lin + 1) % 2400;
          m_col = lin % 80;
          m_row = lin / 80;
        end else if (b == 8'h0A) begin
          m_col = 0; m_row = (m_row + 1) % 30;
        end else if (b == 8'h0D) begin
          m_col = 0;
        end else if (b == 8'h08) begin
          if (m_col > 0) begin
            m_col--;
            put_cell(lin - 1, 8'h20);
          end
        end else if (b == 8'h0C) begin
          m_sweep = 1;
          e_we = 1; e_addr = 0; e_be = 4'hF; e_wd = 32'h20202020;
          e_cwd = {4{m_color}};
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(char_ready_o), 32'(m_sweep == 0));
      chk("busy", 32'(busy_o), 32'(m_sweep != 0));
      chk("we", 32'(char_map_we_o), 32'(e_we));
      chk("col", 32'(cursor_col_o), 32'(m_col));
      chk("row", 32'(cursor_row_o), 32'(m_row));
      if (e_we) begin
        chk("addr", 32'(char_map_addr_o), 32'(e_addr));
        chk("be", 32'(char_map_be_o), 32'(e_be));
        chk("wdata", char_map_wdata_o, e_wd);
      end
`ifdef VGACHARGEN_CONSOLE_COLOR_EN
      chk("col_we", 32'(col_map_we_o), 32'(e_we));
      if (e_we) begin
        chk("col_addr", 32'(col_map_addr_o), 32'(e_addr));
        chk("col_be", 32'(col_map_be_o), 32'(e_be));
        chk("col_wdata", col_map_wdata_o, e_cwd);
      end
`endif
    end
  end

  // Present a byte and wait for acceptance; returns at the negedge where the
  // resulting write is visible. low counts cycles seen with ready low.
  task automatic send(input logic [7:0] b, output int low);
    int n = 0;
    low = 0;
    char_valid_i = 1;
    char_data_i = b;
    do begin
      if (!char_ready_o) low++;
      @(negedge clk);
      n++;
    end while (!m_last_acc && n < 2000);
    if (!m_last_acc) chk("accept_timeout", 32'd0, 32'd1);
    char_valid_i = 0;
  endtask

  task automatic put(input logic [7:0] b);
    int low;
    send(b, low);
  endtask

  task automatic lit_write(input string tag, input int addr, input logic [3:0] be,
                           input logic [31:0] wd);
    chk({tag, "_we"}, 32'(char_map_we_o), 32'd1);
    chk({tag, "_addr"}, 32'(char_map_addr_o), 32'(addr));
    chk({tag, "_be"}, 32'(char_map_be_o), 32'(be));
    chk({tag, "_wdata"}, char_map_wdata_o, wd);
  endtask

  task automatic lit_cursor(input string tag, input int col, input int row);
    chk({tag, "_col"}, 32'(cursor_col_o), 32'(col));
    chk({tag, "_row"}, 32'(cursor_row_o), 32'(row));
  endtask

  initial begin
    int low;
    int r;
    rst_i = 1;
    char_valid_i = 0;
    char_data_i = 0;
    color_i = 0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_we", 32'(char_map_we_o), 32'd0);
    chk("rst_addr", 32'(char_map_addr_o), 32'd0);
    chk("rst_be", 32'(char_map_be_o), 32'd0);
    chk("rst_wdata", char_map_wdata_o, 32'd0);
    chk("rst_ready", 32'(char_ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    lit_cursor("rst", 0, 0);
    rst_i = 0;
    @(negedge clk);

    color_i = 8'h5A;
    put(8'h41);
    lit_write("A", 0, 4'b0001, 32'h41414141);
    lit_cursor("A", 1, 0);

    put(8'h0D);
    for (int i = 0; i < 81; i++) put(8'h78);
    lit_write("x81", 20, 4'b0001, 32'h78787878);
    lit_cursor("x81", 1, 1);

    put(8'h0D);
    for (int i = 0; i < 28; i++) put(8'h0A);
    for (int i = 0; i < 79; i++) put(8'h79);
    lit_cursor("corner", 79, 29);
    put(8'h7A);
    lit_write("z", 599, 4'b1000, 32'h7A7A7A7A);
    lit_cursor("z", 0, 0);

    put(8'h41);
    put(8'h42);
    put(8'h08);
    lit_write("bs1", 0, 4'b0010, 32'h20202020);
    put(8'h08);
    lit_write("bs2", 0, 4'b0001, 32'h20202020);
    put(8'h08);
    chk("bs3_we", 32'(char_map_we_o), 32'd0);
    lit_cursor("bs3", 0, 0);

    put(8'h0C);
    send(8'h51, low);
    chk("ff_ready_low", 32'(low), 32'd600);
    lit_write("Q", 0, 4'b0001, 32'h51515151);
    lit_cursor("Q", 1, 0);

    for (int i = 0; i < 500; i++) begin
      color_i = 8'($urandom);
      r = $urandom_range(0, 99);
      if (r < 25) begin
        char_valid_i = 0;
      end else begin
        char_valid_i = 1;
        r = $urandom_range(0, 99);
        if (r < 70)      char_data_i = 8'($urandom_range(8'h20, 8'h7E));
        else if (r < 78) char_data_i = 8'h0A;
        else if (r < 84) char_data_i = 8'h0D;
        else if (r < 93) char_data_i = 8'h08;
        else if (r < 95) char_data_i = 8'h0C;
        else if (r < 97) char_data_i = 8'($urandom_range(0, 7));
        else             char_data_i = 8'($urandom_range(8'h7F, 8'hFF));
      end
      @(negedge clk);
    end
    char_valid_i = 0;
    while (m_sweep != 0) @(negedge clk);

    put(8'h0C);
    repeat (300) @(negedge clk);
    chk("mid_addr", 32'(char_map_addr_o), 32'd300);
    rst_i = 1;
    @(negedge clk);
    chk("abort_we", 32'(char_map_we_o), 32'd0);
    chk("abort_ready", 32'(char_ready_o), 32'd1);
    lit_cursor("abort", 0, 0);
    rst_i = 0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
